// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA image-memory path.
package vga_pkg;

  localparam int unsigned IMG_W     = 400;
  localparam int unsigned IMG_H     = 400;
  localparam int unsigned IMG_DEPTH = IMG_W * IMG_H;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;
  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Window check done one bit wider than the address so base+length cannot wrap.
  function automatic logic window_fits(input addr_t base, input addr_t len,
                                       input int unsigned depth);
    logic [SUM_W-1:0] end_excl;
    end_excl = {1'b0, base} + {1'b0, len};
    return end_excl <= SUM_W'(depth);
  endfunction

endpackage

// File: rtl/frame_ram_writer_if.sv
// Sample stream in and RAM write port out, bundled for one colour channel.
interface frame_ram_writer_if;
  import vga_pkg::*;

  logic   s_valid;
  pixel_t s_data;
  logic   s_ready;
  logic   mem_we;
  addr_t  mem_addr;
  pixel_t mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/frame_ram_writer.sv
// Writes a base/length window of 8-bit samples from a valid/ready stream into the
// image RAM, one byte per accepted beat with a fixed one-cycle write latency.
module frame_ram_writer
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = IMG_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  addr_t                    base_addr,
  input  addr_t                    length,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  frame_ram_writer_if.slave        bus
);

  wr_state_t state_q, state_d;
  addr_t     base_q,  base_d;
  addr_t     len_q,   len_d;
  addr_t     count_q, count_d;
  logic      mem_we_q, mem_we_d;
  addr_t     mem_addr_q, mem_addr_d;
  pixel_t    mem_wdata_q, mem_wdata_d;
  logic      done_q, done_d;
  logic      err_q, err_d;
  logic      accept_c;

  // Readiness depends on state only, never on s_valid.
  assign bus.s_ready = (state_q == WRITE);
  assign busy        = (state_q == WRITE);
  assign accept_c    = bus.s_valid && (state_q == WRITE);

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign done          = done_q;
  assign err           = err_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else if (!window_fits(base_addr, length, DEPTH)) begin
            err_d = 1'b1;
          end else begin
            base_d  = base_addr;
            len_d   = length;
            count_d = '0;
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        if (accept_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + count_q;
          mem_wdata_d = bus.s_data;
          count_d     = count_q + ADDR_W'(1);
          if (count_q == len_q - ADDR_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        // Abort wins over completion; a beat taken this cycle is still written.
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_frame_ram_writer.sv
// Scoreboard bench for frame_ram_writer: stimulus pushes expected writes/events,
// a negedge monitor pops and compares them including cycle-exact latency.
module tb_frame_ram_writer;
  import vga_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_exp_t;

  typedef struct packed {
    logic        is_err;
    logic        we;
    logic [31:0] cyc;
  } ev_exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;

  frame_ram_writer_if bus ();

  frame_ram_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  wr_exp_t     wq[$];
  ev_exp_t     evq[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every write or done/err pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 64'(bus.mem_we), 64'd0);
      end else begin
        wr_exp_t w;
        w = wq.pop_front();
        check("wr_addr",  64'(bus.mem_addr),  64'(w.addr));
        check("wr_data",  64'(bus.mem_wdata), 64'(w.data));
        check("wr_cycle", 64'(cyc),           64'(w.cyc));
      end
    end
    if (done === 1'b1 || err === 1'b1) begin
      if (evq.size() == 0) begin
        check("unexpected_event", {62'd0, err, done}, 64'd0);
      end else begin
        ev_exp_t e;
        e = evq.pop_front();
        check("ev_is_err", 64'(err),        64'(e.is_err));
        check("ev_we",     64'(bus.mem_we), 64'(e.we));
        check("ev_cycle",  64'(cyc),        64'(e.cyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic is_err, input logic we);
    ev_exp_t e;
    e.is_err = is_err;
    e.we     = we;
    e.cyc    = cyc + 32'd1;
    evq.push_back(e);
  endtask

  // Caller is at posedge+1; start is held for exactly one edge.
  task automatic start_xfer(input logic [31:0] b, input logic [31:0] l);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Streams n samples d0, d0+1, ...; gaps toggles s_valid 1,0,1,0...
  // poke_at pulses an extra start with that beat; abort_at aborts with that beat.
  task automatic send(input logic [31:0] b, input int n, input logic [7:0] d0,
                      input bit gaps, input int poke_at, input int abort_at,
                      input bit exp_done);
    int  i = 0;
    int  c = 0;
    bit  v;
    bit  acc;
    bit  aborted = 1'b0;
    wr_exp_t w;
    while (i < n && c < 100 && !aborted) begin
      v           = gaps ? (c % 2 == 0) : 1'b1;
      bus.s_valid = v;
      bus.s_data  = d0 + 8'(i);
      acc         = v && (bus.s_ready === 1'b1);
      if (acc && i == poke_at) begin
        start = 1'b1; base_addr = 32'd500; length = 32'd1;
      end
      if (acc && i == abort_at) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
      if (acc) begin
        w.addr = b + 32'(i);
        w.data = d0 + 8'(i);
        w.cyc  = cyc + 32'd1;
        wq.push_back(w);
        if (i == n - 1 && exp_done) push_ev(1'b0, 1'b1);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (acc) i++;
      c++;
    end
    bus.s_valid = 1'b0;
    if (!aborted) check("send_beats_accepted", 64'(i), 64'(n));
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    length      = '0;
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    #3;
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_busy",    64'(busy),        64'd0);
    check("rst_mem_we",  64'(bus.mem_we),  64'd0);
    check("rst_done",    64'(done),        64'd0);
    check("rst_err",     64'(err),         64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Basic back-to-back transfer.
    start_xfer(32'd100, 32'd4);
    check("busy_in_write", 64'(busy), 64'd1);
    send(32'd100, 4, 8'hA1, 1'b0, -1, -1, 1'b1);
    idle(3);
    check("busy_after_done", 64'(busy), 64'd0);

    // Gapped valid.
    start_xfer(32'd200, 32'd3);
    send(32'd200, 3, 8'h10, 1'b1, -1, -1, 1'b1);
    idle(3);

    // Window bounds.
    start_xfer(32'd159998, 32'd2);
    send(32'd159998, 2, 8'h55, 1'b0, -1, -1, 1'b1);
    idle(3);
    push_ev(1'b1, 1'b0);
    start_xfer(32'd159999, 32'd2);
    idle(2);
    check("busy_after_err", 64'(busy), 64'd0);
    push_ev(1'b1, 1'b0);
    start_xfer(32'hFFFF_FFFF, 32'd2);
    idle(2);
    check("busy_after_wrap_err", 64'(busy), 64'd0);

    // Zero length completes immediately with no write.
    push_ev(1'b0, 1'b0);
    start_xfer(32'd50, 32'd0);
    idle(2);
    check("busy_after_len0", 64'(busy), 64'd0);

    // A start during WRITE must not disturb the running transfer.
    start_xfer(32'd300, 32'd3);
    send(32'd300, 3, 8'h30, 1'b0, 1, -1, 1'b1);
    idle(3);

    // Abort together with the fifth beat, then a fresh transfer.
    start_xfer(32'd1000, 32'd10);
    send(32'd1000, 10, 8'hC0, 1'b0, -1, 4, 1'b0);
    check("busy_after_abort", 64'(busy), 64'd0);
    idle(3);
    start_xfer(32'd2000, 32'd1);
    send(32'd2000, 1, 8'h77, 1'b0, -1, -1, 1'b1);
    idle(3);

    // Asynchronous reset in the middle of a transfer with a beat pending.
    start_xfer(32'd3000, 32'd10);
    send(32'd3000, 3, 8'hE0, 1'b0, -1, -1, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_s_ready", 64'(bus.s_ready), 64'd0);
    check("async_busy",    64'(busy),        64'd0);
    check("async_mem_we",  64'(bus.mem_we),  64'd0);
    bus.s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check("busy_after_reset", 64'(busy), 64'd0);

    check("writes_outstanding", 64'(wq.size()),  64'd0);
    check("events_outstanding", 64'(evq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
